fetch_stage: RTL

Instruction fetch stage plus IF/ID pipeline register, directly upstream of the decode/control unit.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Holds one fetched instruction in a skid buffer while decode is stalled.
- Flushes on a taken branch and presents IR_out/PC_out/valid_out to decode each cycle.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_stage_if_id_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [XLEN-1:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    // One IF/ID slot: instruction, its fetch address + 4, and a real-instruction flag.
    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc;
        logic            valid;
    } ifid_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// 65-bit IR/PC/valid register with hold and flush; flush wins over load enable.
// Used both for the IF/ID pipeline register and for the single-entry skid buffer.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic  clk_in,
    input  logic  reset_n_in,
    input  logic  le_i,
    input  logic  flush_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t slot_q;
    ifid_t slot_d;

    // Flush keeps the PC field so decode still sees the last known PC on a bubble.
    always_comb begin
        slot_d = slot_q;
        if (flush_i) begin
            slot_d.ir    = NOP_WORD;
            slot_d.valid = 1'b0;
        end else if (le_i) begin
            slot_d = d_i;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            slot_q.ir    <= NOP_WORD;
            slot_q.pc    <= '0;
            slot_q.valid <= 1'b0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack handshake, skid buffer and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch/bubble event counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic [XLEN-1:0] imem_data_in,
    input  logic            imem_ack_in,
    input  logic            LE_IF_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] branch_target_in,
    output logic [XLEN-1:0] IR_out,
    output logic [XLEN-1:0] PC_out,
    output logic            valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt_out,
    output logic [31:0]     bubble_cnt_out
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] pc_inc;
    logic            ack_c;

    ifid_t ifid_q, ifid_d;
    logic  ifid_le, ifid_flush;
    ifid_t skid_q, skid_d;
    logic  skid_le, skid_flush;

    assign pc_inc = pc_q + XLEN'(PC_STEP);
    assign ack_c  = imem_ack_in & req_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_le    = 1'b0;
        ifid_flush = 1'b0;
        ifid_d     = '{ir: imem_data_in, pc: pc_inc, valid: 1'b1};
        skid_le    = 1'b0;
        skid_flush = 1'b0;
        skid_d     = '{ir: imem_data_in, pc: pc_inc, valid: 1'b1};

        if (branch_taken_in) begin
            // Redirect beats stall and ack; an in-flight unacked fetch must be drained in DROP.
            pc_d       = word_align(branch_target_in);
            ifid_flush = 1'b1;
            skid_flush = 1'b1;
            case (state_q)
                FETCH:   state_d = ack_c ? FETCH : DROP;
                DROP:    state_d = DROP;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                BOOT: state_d = FETCH;
                FETCH: begin
                    if (ack_c) begin
                        pc_d = pc_inc;
                        if (LE_IF_in) begin
                            ifid_le = 1'b1;
                        end else begin
                            skid_le = 1'b1;
                            state_d = HELD;
                        end
                    end else if (LE_IF_in) begin
                        ifid_flush = 1'b1;
                    end
                end
                HELD: begin
                    if (LE_IF_in) begin
                        ifid_le = 1'b1;
                        ifid_d  = skid_q;
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    if (LE_IF_in) begin
                        ifid_flush = 1'b1;
                    end
                    if (ack_c) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = BOOT;
            endcase
        end

        req_d  = (state_d == FETCH) || (state_d == DROP);
        // DROP keeps presenting the stale address until its ack retires it.
        addr_d = (state_d == DROP) ? addr_q : pc_d;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= BOOT;
            pc_q    <= word_align(RESET_PC);
            addr_q  <= word_align(RESET_PC);
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    if_id_reg #(.NOP_WORD(NOP_WORD)) u_ifid (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .le_i       (ifid_le),
        .flush_i    (ifid_flush),
        .d_i        (ifid_d),
        .q_o        (ifid_q)
    );

    if_id_reg #(.NOP_WORD(NOP_WORD)) u_skid (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .le_i       (skid_le),
        .flush_i    (skid_flush),
        .d_i        (skid_d),
        .q_o        (skid_q)
    );

    assign imem_req_out  = req_q;
    assign imem_addr_out = addr_q;
    assign IR_out        = ifid_q.ir;
    assign PC_out        = ifid_q.pc;
    assign valid_out     = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    // Every valid=0 load of IF/ID goes through flush, every valid=1 load through le.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (ifid_le && !ifid_flush) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (ifid_flush) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_out  = fetch_cnt_q;
    assign bubble_cnt_out = bubble_cnt_q;
`else
    // Counters are absent in this build.
`endif

endmodule
